paddle_input_ctrl: RTL and testbench

//   Turns two raw push-buttons into one paddle position for pong_logic and pong_renderer.
//   Per button: 2-FF synchroniser, then a counter debouncer.
//   The paddle moves SPEED pixels per frame while a button is held, clamped to the screen.

---
 rtl/paddle_input_ctrl.sv | 162 ++++++++++++++++
 tb/tb_paddle_input_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_input_ctrl.sv
// Paddle position controller: two raw push-buttons are synchronised and debounced,
// then move the paddle SPEED pixels per frame_tick, clamped to the legal screen range.

module paddle_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk_0,
  input  logic rst,
  input  logic btn_raw,
  output logic pressed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic RELEASED_RAW = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]       sync_q;
  logic             sync_pressed;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  // Sync flops hold the raw pin level; polarity is normalised only after the second flop.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      sync_q <= {2{RELEASED_RAW}};
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign sync_pressed = sync_q[1] ^ RELEASED_RAW;

  // The stable level only follows the synchronised level once it has differed for
  // DEBOUNCE_CYCLES consecutive edges; any return to the stable level restarts the count.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (sync_pressed == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_q <= sync_pressed;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pressed = stable_q;

endmodule

module paddle_input_ctrl #(
  parameter int unsigned PADDLE_X        = 10,
  parameter int unsigned PADDLE_H        = 80,
  parameter int unsigned Y_INIT          = 200,
  parameter int unsigned Y_MIN           = 0,
  parameter int unsigned Y_MAX           = 480,
  parameter int unsigned SPEED           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       frame_tick,
  output logic [9:0] paddle_xpos,
  output logic [9:0] paddle_ypos,
  output logic       up_pressed,
  output logic       down_pressed
);

  // All position arithmetic is carried one bit wider than the port so that
  // neither the subtraction nor the addition can wrap before the clamp.
  localparam logic [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic [10:0] Y_HI   = 11'(Y_MAX - PADDLE_H);
  localparam logic [10:0] STEP   = 11'(SPEED);
  localparam logic [10:0] Y_BOOT = 11'(Y_INIT);

  typedef enum logic [1:0] {
    MOVE_HOLD,
    MOVE_UP,
    MOVE_DOWN
  } move_e;

  logic        up_db;
  logic        down_db;
  move_e       move_dir;
  logic [10:0] ypos_q;
  logic [10:0] ypos_next;

  paddle_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (BTN_ACTIVE_LOW)
  ) u_db_up (
    .clk_0   (clk_0),
    .rst     (rst),
    .btn_raw (btn_up),
    .pressed (up_db)
  );

  paddle_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (BTN_ACTIVE_LOW)
  ) u_db_down (
    .clk_0   (clk_0),
    .rst     (rst),
    .btn_raw (btn_down),
    .pressed (down_db)
  );

  // Opposing buttons cancel, so only an exclusive press moves the paddle.
  always_comb begin
    move_dir = MOVE_HOLD;
    if (up_db && !down_db) begin
      move_dir = MOVE_UP;
    end else if (down_db && !up_db) begin
      move_dir = MOVE_DOWN;
    end
  end

  always_comb begin
    ypos_next = ypos_q;
    if (frame_tick) begin
      case (move_dir)
        MOVE_UP: begin
          if (ypos_q >= Y_LO + STEP) begin
            ypos_next = ypos_q - STEP;
          end else begin
            ypos_next = Y_LO;
          end
        end
        MOVE_DOWN: begin
          if (ypos_q + STEP <= Y_HI) begin
            ypos_next = ypos_q + STEP;
          end else begin
            ypos_next = Y_HI;
          end
        end
        default: ypos_next = ypos_q;
      endcase
    end
  end

  // The debounced flags are registered, so a debounce update on a frame_tick edge
  // only affects movement from the following tick onward.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      ypos_q <= Y_BOOT;
    end else begin
      ypos_q <= ypos_next;
    end
  end

  assign paddle_xpos  = 10'(PADDLE_X);
  assign paddle_ypos  = ypos_q[9:0];
  assign up_pressed   = up_db;
  assign down_pressed = down_db;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Self-checking bench for paddle_input_ctrl: directed scenarios plus randomized button
// and frame_tick activity, all compared against a behavioural model of the paddle.

module tb_paddle_input_ctrl;

  localparam int DB      = 4;
  localparam int SPD     = 4;
  localparam int YLIMIT  = 400;
  localparam int Y_INIT  = 200;
  localparam int Y_INIT2 = 6;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       frame_tick;
  logic [9:0] paddle_xpos;
  logic [9:0] paddle_ypos;
  logic       up_pressed;
  logic       down_pressed;
  logic [9:0] paddle_xpos2;
  logic [9:0] paddle_ypos2;
  logic       up_pressed2;
  logic       down_pressed2;

  int n_cmp;
  int n_fail;

  int m_ypos;
  int m_ypos2;
  bit m_up;
  bit m_down;
  int run_up;
  int run_down;
  bit q_up[$];
  bit q_down[$];

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .SPEED           (SPD)
  ) dut (
    .clk_0        (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .frame_tick   (frame_tick),
    .paddle_xpos  (paddle_xpos),
    .paddle_ypos  (paddle_ypos),
    .up_pressed   (up_pressed),
    .down_pressed (down_pressed)
  );

  // Second instance starts off the SPEED grid so the top clamp is hit from 2.
  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .SPEED           (SPD),
    .Y_INIT          (Y_INIT2)
  ) dut_odd (
    .clk_0        (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .frame_tick   (frame_tick),
    .paddle_xpos  (paddle_xpos2),
    .paddle_ypos  (paddle_ypos2),
    .up_pressed   (up_pressed2),
    .down_pressed (down_pressed2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int move_model(int y, bit up, bit down);
    if (up && !down) return (y - SPD < 0) ? 0 : y - SPD;
    if (down && !up) return (y + SPD > YLIMIT) ? YLIMIT : y + SPD;
    return y;
  endfunction

  // A pin sample reaches the debouncer two edges later; the flag flips once that
  // delayed sample has disagreed with the flag on DB consecutive edges.
  function automatic void model_edge();
    bit d_up;
    bit d_down;
    if (rst) begin
      m_ypos = Y_INIT; m_ypos2 = Y_INIT2;
      m_up = 0; m_down = 0; run_up = 0; run_down = 0;
      q_up = '{0, 0}; q_down = '{0, 0};
      return;
    end
    if (frame_tick) begin
      m_ypos  = move_model(m_ypos, m_up, m_down);
      m_ypos2 = move_model(m_ypos2, m_up, m_down);
    end
    d_up = q_up.pop_front();
    d_down = q_down.pop_front();
    if (d_up != m_up) begin
      run_up++;
      if (run_up == DB) begin m_up = d_up; run_up = 0; end
    end else run_up = 0;
    if (d_down != m_down) begin
      run_down++;
      if (run_down == DB) begin m_down = d_down; run_down = 0; end
    end else run_down = 0;
    q_up.push_back(btn_up == 1'b0);
    q_down.push_back(btn_down == 1'b0);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; btn_up = 1; btn_down = 1; frame_tick = 0;
    step(); step();
    rst = 0;
    n_cmp++; if (paddle_ypos !== 10'(Y_INIT)) begin n_fail++; $display("[TB] FAIL reset_ypos: got %0d want %0d", paddle_ypos, Y_INIT); end
    n_cmp++; if (paddle_ypos2 !== 10'(Y_INIT2)) begin n_fail++; $display("[TB] FAIL reset_ypos2: got %0d want %0d", paddle_ypos2, Y_INIT2); end
    n_cmp++; if (paddle_xpos !== 10'd10) begin n_fail++; $display("[TB] FAIL reset_xpos: got %0d want 10", paddle_xpos); end
    n_cmp++; if ({up_pressed, down_pressed} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_flags: got %b%b want 00", up_pressed, down_pressed); end
    for (int i = 0; i < 10; i++) begin
      frame_tick = 1; step();
      frame_tick = 0; step();
      n_cmp++; if (paddle_ypos !== 10'(Y_INIT)) begin n_fail++; $display("[TB] FAIL idle_tick%0d: got %0d want %0d", i, paddle_ypos, Y_INIT); end
    end
  endtask

  task automatic test_up_hold();
    int exp_y[3] = '{196, 192, 188};
    int exp_y2[3] = '{2, 0, 0};
    btn_up = 0;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_cmp++; if (up_pressed !== (e >= 6)) begin n_fail++; $display("[TB] FAIL up_latency_e%0d: got %b want %b", e, up_pressed, e >= 6); end
    end
    for (int k = 0; k < 3; k++) begin
      frame_tick = 1; step(); frame_tick = 0;
      n_cmp++; if (paddle_ypos !== 10'(exp_y[k])) begin n_fail++; $display("[TB] FAIL up_move%0d: got %0d want %0d", k, paddle_ypos, exp_y[k]); end
      n_cmp++; if (paddle_ypos2 !== 10'(exp_y2[k])) begin n_fail++; $display("[TB] FAIL top_clamp%0d: got %0d want %0d", k, paddle_ypos2, exp_y2[k]); end
    end
    step();
  endtask

  task automatic test_down_bounce();
    btn_up = 1;
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (up_pressed !== 1'b0) begin n_fail++; $display("[TB] FAIL up_release: got %b want 0", up_pressed); end
    for (int e = 1; e <= 12; e++) begin
      btn_down = (e == 4) ? 1'b1 : 1'b0;
      step();
      n_cmp++; if (down_pressed !== (e >= 10)) begin n_fail++; $display("[TB] FAIL bounce_e%0d: got %b want %b", e, down_pressed, e >= 10); end
      n_cmp++; if (down_pressed !== m_down) begin n_fail++; $display("[TB] FAIL bounce_model_e%0d: got %b want %b", e, down_pressed, m_down); end
    end
  endtask

  task automatic test_down_clamp();
    for (int i = 0; i < 200 && m_ypos < 396; i++) begin
      frame_tick = 1; step(); frame_tick = 0;
      n_cmp++; if (paddle_ypos !== 10'(m_ypos)) begin n_fail++; $display("[TB] FAIL down_walk%0d: got %0d want %0d", i, paddle_ypos, m_ypos); end
    end
    n_cmp++; if (paddle_ypos !== 10'd396) begin n_fail++; $display("[TB] FAIL down_at396: got %0d want 396", paddle_ypos); end
    for (int k = 0; k < 4; k++) begin
      frame_tick = 1; step(); frame_tick = 0;
      n_cmp++; if (paddle_ypos !== 10'd400) begin n_fail++; $display("[TB] FAIL bottom_clamp%0d: got %0d want 400", k, paddle_ypos); end
    end
  endtask

  task automatic test_up_clamp();
    btn_down = 1; btn_up = 0;
    for (int i = 0; i < 8; i++) step();
    n_cmp++; if ({up_pressed, down_pressed} !== 2'b10) begin n_fail++; $display("[TB] FAIL swap_flags: got %b%b want 10", up_pressed, down_pressed); end
    for (int i = 0; i < 200 && m_ypos > 4; i++) begin
      frame_tick = 1; step(); frame_tick = 0;
    end
    n_cmp++; if (paddle_ypos !== 10'd4) begin n_fail++; $display("[TB] FAIL up_at4: got %0d want 4", paddle_ypos); end
    for (int k = 0; k < 4; k++) begin
      frame_tick = 1; step(); frame_tick = 0;
      n_cmp++; if (paddle_ypos !== 10'd0) begin n_fail++; $display("[TB] FAIL top_clamp_main%0d: got %0d want 0", k, paddle_ypos); end
    end
  endtask

  task automatic test_both_and_reset();
    btn_down = 0;
    for (int i = 0; i < 8; i++) step();
    n_cmp++; if ({up_pressed, down_pressed} !== 2'b11) begin n_fail++; $display("[TB] FAIL both_flags: got %b%b want 11", up_pressed, down_pressed); end
    for (int k = 0; k < 5; k++) begin
      frame_tick = 1; step(); frame_tick = 0;
      n_cmp++; if (paddle_ypos !== 10'd0) begin n_fail++; $display("[TB] FAIL both_hold%0d: got %0d want 0", k, paddle_ypos); end
    end
    rst = 1; btn_down = 1; frame_tick = 1;
    step();
    rst = 0; frame_tick = 0;
    n_cmp++; if (paddle_ypos !== 10'(Y_INIT)) begin n_fail++; $display("[TB] FAIL midhold_rst_ypos: got %0d want %0d", paddle_ypos, Y_INIT); end
    n_cmp++; if ({up_pressed, down_pressed} !== 2'b00) begin n_fail++; $display("[TB] FAIL midhold_rst_flags: got %b%b want 00", up_pressed, down_pressed); end
  endtask

  task automatic test_same_edge();
    for (int e = 1; e <= 6; e++) begin
      frame_tick = (e == 6);
      step();
    end
    frame_tick = 0;
    n_cmp++; if (up_pressed !== 1'b1) begin n_fail++; $display("[TB] FAIL same_edge_flag: got %b want 1", up_pressed); end
    n_cmp++; if (paddle_ypos !== 10'(Y_INIT)) begin n_fail++; $display("[TB] FAIL same_edge_nomove: got %0d want %0d", paddle_ypos, Y_INIT); end
    step();
    frame_tick = 1; step(); frame_tick = 0;
    n_cmp++; if (paddle_ypos !== 10'(Y_INIT - 4)) begin n_fail++; $display("[TB] FAIL same_edge_next: got %0d want %0d", paddle_ypos, Y_INIT - 4); end
  endtask

  task automatic test_random();
    int hold_up = 0;
    int hold_dn = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold_up == 0) begin btn_up = 1'($urandom_range(0, 1)); hold_up = $urandom_range(1, 9); end
      if (hold_dn == 0) begin btn_down = 1'($urandom_range(0, 1)); hold_dn = $urandom_range(1, 9); end
      hold_up--; hold_dn--;
      frame_tick = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
      n_cmp++; if (paddle_ypos !== 10'(m_ypos)) begin n_fail++; $display("[TB] FAIL rand_ypos_c%0d: got %0d want %0d", c, paddle_ypos, m_ypos); end
      n_cmp++; if (paddle_ypos2 !== 10'(m_ypos2)) begin n_fail++; $display("[TB] FAIL rand_ypos2_c%0d: got %0d want %0d", c, paddle_ypos2, m_ypos2); end
      n_cmp++; if (up_pressed !== m_up) begin n_fail++; $display("[TB] FAIL rand_up_c%0d: got %b want %b", c, up_pressed, m_up); end
      n_cmp++; if (down_pressed !== m_down) begin n_fail++; $display("[TB] FAIL rand_down_c%0d: got %b want %b", c, down_pressed, m_down); end
    end
    rst = 0; frame_tick = 0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1; btn_up = 1; btn_down = 1; frame_tick = 0;
    test_reset();
    test_up_hold();
    test_down_bounce();
    test_down_clamp();
    test_up_clamp();
    test_both_and_reset();
    test_same_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
